// File: rtl/gradient_row_sobel.sv
// gradient_row_sobel: 3-row window Sobel X/Y, magnitude and direction, one interior column per clock.
// Define GRADIENT_ANGLE_EN to build the direction quantizer; otherwise gradient_angle reads 0.
//   state | meaning
//   IDLE  | waiting for a row strobe
//   CALC  | computing one interior column per clock
//   DONE  | all results written, gradient_final high
module gradient_row_sobel #(
  parameter int NUM_COLS = 16,
  parameter int PIX_W    = 8
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             anchor_moving,
  input  logic [31:0]                      anchor_x,
  input  logic [NUM_COLS-1:0][PIX_W-1:0]   gradient_in,
  output logic [NUM_COLS-3:0][1:0]         gradient_angle,
  output logic [NUM_COLS-3:0][PIX_W-1:0]   gradient_mag,
  output logic [NUM_COLS-3:0][PIX_W+2:0]   gradient_x,
  output logic [NUM_COLS-3:0][PIX_W+2:0]   gradient_y,
  output logic                             gradient_final
);
  localparam int OUT_N = NUM_COLS - 2;
  localparam int GW    = PIX_W + 3;
  localparam int CW    = $clog2(NUM_COLS);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef logic [NUM_COLS-1:0][PIX_W-1:0] row_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              col_q, col_d;
  row_t                       top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic [OUT_N-1:0][1:0]      ang_q, ang_d;
  logic [OUT_N-1:0][PIX_W-1:0] mag_q, mag_d;
  logic [OUT_N-1:0][GW-1:0]   gx_q, gx_d, gy_q, gy_d;
  logic                       final_q, final_d;

  function automatic logic signed [GW:0] px(input logic [PIX_W-1:0] p);
    return signed'({{(GW+1-PIX_W){1'b0}}, p});
  endfunction

  logic [CW-1:0]      c1, c2;
  logic signed [GW:0] gx_w, gy_w, ax_w, ay_w;
  logic [GW-1:0]      ax, ay, mag_sum;
  logic [1:0]         ang_new;

  assign c1 = col_q + CW'(1);
  assign c2 = col_q + CW'(2);

  // Shared datapath: window columns col_q..col_q+2 feed output index col_q.
  always_comb begin
    gx_w = (px(top_q[c2]) - px(top_q[col_q]))
         + ((px(mid_q[c2]) - px(mid_q[col_q])) <<< 1)
         + (px(bot_q[c2]) - px(bot_q[col_q]));
    gy_w = (px(top_q[col_q]) + (px(top_q[c1]) <<< 1) + px(top_q[c2]))
         - (px(bot_q[col_q]) + (px(bot_q[c1]) <<< 1) + px(bot_q[c2]));
    ax_w    = gx_w[GW] ? -gx_w : gx_w;
    ay_w    = gy_w[GW] ? -gy_w : gy_w;
    ax      = GW'(ax_w);
    ay      = GW'(ay_w);
    mag_sum = ax + ay;
  end

`ifdef GRADIENT_ANGLE_EN
  logic [GW+1:0] ax2, ay2, ax5, ay5;
  // A flat patch (gx=gy=0) has no direction and is reported as horizontal.
  always_comb begin
    ax2 = {1'b0, ax, 1'b0};
    ay2 = {1'b0, ay, 1'b0};
    ax5 = ({2'b0, ax} << 2) + {2'b0, ax};
    ay5 = ({2'b0, ay} << 2) + {2'b0, ay};
    if ((ay5 < ax2) || ((ax == '0) && (ay == '0))) ang_new = 2'd0;
    else if (ay2 > ax5)                              ang_new = 2'd2;
    else if (gx_w[GW] == gy_w[GW])                   ang_new = 2'd1;
    else                                             ang_new = 2'd3;
  end
`else
  assign ang_new = 2'd0;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    top_d   = top_q;
    mid_d   = mid_q;
    bot_d   = bot_q;
    ang_d   = ang_q;
    mag_d   = mag_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    final_d = 1'b0;
    case (state_q)
      IDLE: if (anchor_moving) begin
        if (anchor_x == 32'd1) begin
          top_d = gradient_in;
          mid_d = gradient_in;
          bot_d = gradient_in;
        end else begin
          top_d = mid_q;
          mid_d = bot_q;
          bot_d = gradient_in;
        end
        col_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        gx_d[col_q]  = GW'(gx_w);
        gy_d[col_q]  = GW'(gy_w);
        mag_d[col_q] = PIX_W'(mag_sum >> 3);
        ang_d[col_q] = ang_new;
        if (col_q == CW'(OUT_N - 1)) begin
          state_d = DONE;
          final_d = 1'b1;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      ang_q   <= '0;
      mag_q   <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      top_q   <= top_d;
      mid_q   <= mid_d;
      bot_q   <= bot_d;
      ang_q   <= ang_d;
      mag_q   <= mag_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      final_q <= final_d;
    end
  end

  assign gradient_angle = ang_q;
  assign gradient_mag   = mag_q;
  assign gradient_x     = gx_q;
  assign gradient_y     = gy_q;
  assign gradient_final = final_q;

endmodule

// File: tb/tb_gradient_row_sobel.sv
// Scoreboard bench for gradient_row_sobel: a row-window model pushes expected results, a monitor checks each final pulse.
module tb_gradient_row_sobel;
  typedef logic [15:0][7:0] row_t;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              anchor_moving;
  logic [31:0]       anchor_x;
  row_t              gradient_in;
  logic [13:0][1:0]  gradient_angle;
  logic [13:0][7:0]  gradient_mag;
  logic [13:0][10:0] gradient_x;
  logic [13:0][10:0] gradient_y;
  logic              gradient_final;

  gradient_row_sobel dut (
    .clk(clk), .n_rst(n_rst), .anchor_moving(anchor_moving), .anchor_x(anchor_x),
    .gradient_in(gradient_in), .gradient_angle(gradient_angle), .gradient_mag(gradient_mag),
    .gradient_x(gradient_x), .gradient_y(gradient_y), .gradient_final(gradient_final)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int win_top[16], win_mid[16], win_bot[16];
  int q_gx[$], q_gy[$], q_mag[$], q_ang[$];
  longint q_due[$];

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: update the window by the row rules, then evaluate the Sobel formulas with plain integers.
  task automatic model_push(input row_t row, input int anc, input longint due);
    int gx, gy, agx, agy, ang;
    for (int j = 0; j < 16; j++) begin
      if (anc == 1) begin
        win_top[j] = int'(row[j]); win_mid[j] = int'(row[j]); win_bot[j] = int'(row[j]);
      end else begin
        win_top[j] = win_mid[j]; win_mid[j] = win_bot[j]; win_bot[j] = int'(row[j]);
      end
    end
    for (int k = 0; k < 14; k++) begin
      gx = (win_top[k+2] - win_top[k]) + 2 * (win_mid[k+2] - win_mid[k]) + (win_bot[k+2] - win_bot[k]);
      gy = (win_top[k] + 2 * win_top[k+1] + win_top[k+2]) - (win_bot[k] + 2 * win_bot[k+1] + win_bot[k+2]);
      agx = iabs(gx);
      agy = iabs(gy);
`ifdef GRADIENT_ANGLE_EN
      if (gx == 0 && gy == 0)           ang = 0;
      else if (5 * agy < 2 * agx)       ang = 0;
      else if (2 * agy > 5 * agx)       ang = 2;
      else if ((gx >= 0) == (gy >= 0))  ang = 1;
      else                              ang = 3;
`else
      ang = 0;
`endif
      q_gx.push_back(gx);
      q_gy.push_back(gy);
      q_mag.push_back((agx + agy) / 8);
      q_ang.push_back(ang);
    end
    q_due.push_back(due);
  endtask

  // Strobe is sampled at the next posedge (E0); final is visible at the negedge after E14.
  task automatic send_row(input row_t row, input int anc, input bit expect_it);
    @(negedge clk);
    gradient_in   = row;
    anchor_x      = anc;
    anchor_moving = 1'b1;
    if (expect_it) model_push(row, anc, cyc + 15);
    @(negedge clk);
    anchor_moving = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q_due.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q_due.size() != 0) begin
      chk("drain_timeout", 0, q_due.size(), 0);
      q_due.delete(); q_gx.delete(); q_gy.delete(); q_mag.delete(); q_ang.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 14; k++) begin
      chk({tag, "_gx"}, k, gradient_x[k], 0);
      chk({tag, "_gy"}, k, gradient_y[k], 0);
      chk({tag, "_mag"}, k, gradient_mag[k], 0);
      chk({tag, "_ang"}, k, gradient_angle[k], 0);
    end
    chk({tag, "_final"}, 0, gradient_final, 0);
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int j = 0; j < 16; j++) r[j] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // Monitor: every final pulse must match the oldest outstanding pass, at the expected cycle.
  initial begin
    int v;
    longint due;
    forever begin
      @(negedge clk);
      if (n_rst && gradient_final) begin
        if (q_due.size() == 0) begin
          chk("unexpected_final", 0, 1, 0);
        end else begin
          due = q_due.pop_front();
          chk("latency", 0, cyc, due);
          for (int k = 0; k < 14; k++) begin
            v = $signed(gradient_x[k]);
            chk("gx", k, v, q_gx.pop_front());
            v = $signed(gradient_y[k]);
            chk("gy", k, v, q_gy.pop_front());
            chk("mag", k, gradient_mag[k], q_mag.pop_front());
            chk("ang", k, gradient_angle[k], q_ang.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    row_t r, r2;
    n_rst = 1'b0; anchor_moving = 1'b0; anchor_x = 32'd0; gradient_in = '0;
    for (int j = 0; j < 16; j++) begin win_top[j] = 0; win_mid[j] = 0; win_bot[j] = 0; end
    repeat (3) @(negedge clk);
    check_zero("reset");
    n_rst = 1'b1;
    @(negedge clk);

    for (int j = 0; j < 16; j++) r[j] = 8'd100;
    send_row(r, 1, 1);
    wait_drain();

    for (int j = 0; j < 16; j++) r[j] = (j < 8) ? 8'd0 : 8'd255;
    send_row(r, 1, 1);
    wait_drain();

    r = '0;
    send_row(r, 1, 1);
    wait_drain();
    for (int j = 0; j < 16; j++) r[j] = 8'd200;
    send_row(r, 2, 1);
    wait_drain();

    for (int i = 1; i <= 10; i++) begin
      send_row(rand_row(), i, 1);
      wait_drain();
    end

    // A strobe during CALC must neither restart nor disturb the window.
    r  = rand_row();
    r2 = rand_row();
    send_row(r, 1, 1);
    repeat (3) @(negedge clk);
    send_row(r2, 1, 0);
    wait_drain();
    send_row(rand_row(), 7, 1);
    wait_drain();

    // Reset in the fifth CALC cycle aborts the pass.
    send_row(rand_row(), 1, 0);
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    for (int j = 0; j < 16; j++) begin win_top[j] = 0; win_mid[j] = 0; win_bot[j] = 0; end
    #2;
    check_zero("abort");
    @(negedge clk);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    check_zero("post_abort");
    send_row(rand_row(), 1, 1);
    wait_drain();
    send_row(rand_row(), 3, 1);
    wait_drain();

    chk("pending", 0, q_due.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
